// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 constants and the dot-product sequencer state encoding.
package dlfloat_pkg;
    localparam int DLF_W = 16;
    localparam logic [DLF_W-1:0] DLF_INF  = 16'hFFFF;
    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
    localparam int unsigned MAC_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // The all-ones pattern is the MAC's saturated/special encoding.
    function automatic logic dlf_is_special(input logic [DLF_W-1:0] v);
        return v == DLF_INF;
    endfunction
endpackage

// File: rtl/dlfloat_dot_sequencer.sv
// Sequences the DLFloat16 MAC: clear, issue N operand pairs, drain the
// pipeline, then hold the captured dot product until it is accepted.
module dlfloat_dot_sequencer
    import dlfloat_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAC_LAT = MAC_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [DLF_W-1:0] op_a,
    input  logic [DLF_W-1:0] op_b,
    output logic             mac_clr,
    output logic             mac_issue,
    output logic [DLF_W-1:0] mac_a,
    output logic [DLF_W-1:0] mac_b,
    input  logic [DLF_W-1:0] mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DLF_W-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);
    localparam int unsigned DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    seq_state_t         state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic [DRAIN_W-1:0] drain;
    logic               aborting;
    logic               op_fire;
    logic               last_op;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign aborting  = abort && (state != IDLE);

    // Abort wins over a same-cycle operand handshake, so the pair stays with the source.
    assign op_ready  = (state == LOAD) && !abort;
    assign op_fire   = op_valid && op_ready;

    // Comparing against len-1 keeps cnt inside LEN_W bits even for the maximum length.
    assign last_op   = (cnt == (len_q - LEN_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            drain     <= '0;
            mac_clr   <= 1'b0;
            mac_issue <= 1'b0;
            mac_a     <= DLF_ZERO;
            mac_b     <= DLF_ZERO;
            res_valid <= 1'b0;
            res_data  <= DLF_ZERO;
            res_ovf   <= 1'b0;
        end else begin
            // Issue slots default to a zeroed bubble; only an accepted pair fills one.
            mac_clr   <= 1'b0;
            mac_issue <= 1'b0;
            mac_a     <= DLF_ZERO;
            mac_b     <= DLF_ZERO;

            if (aborting) begin
                state     <= IDLE;
                res_valid <= 1'b0;
                cnt       <= '0;
                drain     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            len_q   <= cmd_len;
                            mac_clr <= 1'b1;
                            state   <= CLEAR;
                        end
                    end

                    CLEAR: begin
                        cnt <= '0;
                        if (len_q == '0) begin
                            drain <= DRAIN_W'(MAC_LAT);
                            state <= DRAIN;
                        end else begin
                            state <= LOAD;
                        end
                    end

                    LOAD: begin
                        if (op_fire) begin
                            mac_issue <= 1'b1;
                            mac_a     <= op_a;
                            mac_b     <= op_b;
                            cnt       <= cnt + LEN_W'(1);
                            if (last_op) begin
                                drain <= DRAIN_W'(MAC_LAT);
                                state <= DRAIN;
                            end
                        end
                    end

                    // The count hits zero in the cycle where the final product is on mac_acc.
                    DRAIN: begin
                        if (drain == '0) begin
                            res_data  <= mac_acc;
                            res_ovf   <= dlf_is_special(mac_acc);
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            drain <= drain - DRAIN_W'(1);
                        end
                    end

                    DONE: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dlfloat_dot_sequencer.sv
// Scoreboard bench for dlfloat_dot_sequencer with a behavioural DLFloat16 MAC
// model; expected dot products come from folding the operand pairs in plain reals.
module tb_dlfloat_dot_sequencer;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             abort;
    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic             mac_clr;
    logic             mac_issue;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic [15:0]      mac_acc;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             res_ovf;
    logic             busy;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
        int          n;
        int          t0;
        bit          chk_lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] op_a_q[$];
    logic [15:0] op_b_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    dlfloat_dot_sequencer #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mac_clr   (mac_clr),
        .mac_issue (mac_issue),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real dlf_decode(input logic [15:0] x);
        real m;
        int  e;
        if (x[14:9] == 6'd0) return 0.0;
        m = 1.0 + real'(int'(x[8:0])) / 512.0;
        e = int'(x[14:9]) - 31;
        for (int i = 0; i < e; i++) m = m * 2.0;
        for (int i = 0; i < -e; i++) m = m / 2.0;
        return x[15] ? -m : m;
    endfunction

    // Truncating encode; out-of-range magnitudes saturate to the special code.
    function automatic logic [15:0] dlf_encode(input real v);
        real  m;
        int   e;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 31;
        for (int i = 0; i < 100 && m >= 2.0; i++) begin m = m / 2.0; e++; end
        for (int i = 0; i < 100 && m < 1.0; i++) begin m = m * 2.0; e--; end
        if (e >= 63) return 16'hFFFF;
        if (e <= 0) return 16'h0000;
        return {s, 6'(e), 9'($rtoi((m - 1.0) * 512.0))};
    endfunction

    function automatic logic [15:0] dlf_mac_step(input logic [15:0] acc, input logic [15:0] a,
                                                  input logic [15:0] b);
        if (acc == 16'hFFFF || a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        return dlf_encode(dlf_decode(acc) + dlf_decode(a) * dlf_decode(b));
    endfunction

    // Behavioural MAC: operands registered on the issue edge, accumulated one edge later.
    logic        st_v;
    logic [15:0] st_a, st_b;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_v    <= 1'b0;
            st_a    <= 16'h0;
            st_b    <= 16'h0;
            mac_acc <= 16'h0;
        end else begin
            st_v <= mac_issue && !mac_clr;
            st_a <= mac_a;
            st_b <= mac_b;
            if (mac_clr) mac_acc <= 16'h0;
            else if (st_v) mac_acc <= dlf_mac_step(mac_acc, st_a, st_b);
        end
    end

    task automatic check_output(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic report_timeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got no handshake, required one within the cycle budget", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        check_output({tag, "_op_ready"},  int'(op_ready),  0);
        check_output({tag, "_mac_clr"},   int'(mac_clr),   0);
        check_output({tag, "_mac_issue"}, int'(mac_issue), 0);
        check_output({tag, "_mac_a"},     int'(mac_a),     0);
        check_output({tag, "_mac_b"},     int'(mac_b),     0);
        check_output({tag, "_res_valid"}, int'(res_valid), 0);
        check_output({tag, "_res_data"},  int'(res_data),  0);
        check_output({tag, "_res_ovf"},   int'(res_ovf),   0);
        check_output({tag, "_busy"},      int'(busy),      0);
    endtask

    task automatic monitor_loop();
        int          issue_cnt  = 0;
        int          rise_cyc   = 0;
        bit          prev_rv    = 1'b0;
        bit          prev_taken = 1'b0;
        logic [15:0] prev_data  = 16'h0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                issue_cnt  = 0;
                prev_rv    = 1'b0;
                prev_taken = 1'b0;
                continue;
            end
            if (mac_clr) issue_cnt = 0;
            if (mac_issue) issue_cnt++;
            if (res_valid && !prev_rv) rise_cyc = cyc;
            if (res_valid) check_output("cmd_ready_while_result", int'(cmd_ready), 0);
            if (res_valid && prev_rv && !prev_taken)
                check_output("res_data_stable", int'(res_data), int'(prev_data));
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_result: got res_data %0h, required no result",
                             res_data);
                end else begin
                    e = sb_q.pop_front();
                    check_output("res_data", int'(res_data), int'(e.data));
                    check_output("res_ovf", int'(res_ovf), int'(e.ovf));
                    check_output("issue_count", issue_cnt, e.n);
                    if (e.chk_lat) check_output("res_latency", rise_cyc, e.t0 + e.n + 2 + MAC_LAT);
                end
            end
            prev_rv    = res_valid;
            prev_data  = res_data;
            prev_taken = res_valid && res_ready;
        end
    endtask

    task automatic send_cmd(input int len, output int t0, output bit ok);
        ok        = 1'b0;
        t0        = 0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                t0 = cyc + 1;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!ok) report_timeout("cmd_accept_timeout");
    endtask

    // mode 0: back-to-back, 1: one idle cycle between pairs, 2: random gaps.
    task automatic send_ops(input int mode);
        bit ok;
        for (int k = 0; k < op_a_q.size(); k++) begin
            if (mode == 1 && k > 0) begin
                op_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            if (mode == 2) begin
                op_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            op_valid = 1'b1;
            op_a     = op_a_q[k];
            op_b     = op_b_q[k];
            ok       = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (op_ready) begin ok = 1'b1; break; end
            end
            @(posedge clk);
            #1;
            if (!ok) begin
                report_timeout("op_accept_timeout");
                break;
            end
        end
        op_valid = 1'b0;
        op_a     = 16'h0;
        op_b     = 16'h0;
    endtask

    task automatic apply_stimulus(input int len, input int mode, input bit expect_res,
                                  input int exp_fixed);
        exp_t        e;
        int          t0;
        bit          ok;
        logic [15:0] acc;
        acc = 16'h0000;
        for (int k = 0; k < len; k++) acc = dlf_mac_step(acc, op_a_q[k], op_b_q[k]);
        if (exp_fixed >= 0) acc = 16'(exp_fixed);
        send_cmd(len, t0, ok);
        if (ok && expect_res) begin
            e.data    = acc;
            e.ovf     = (acc == 16'hFFFF);
            e.n       = len;
            e.t0      = t0;
            e.chk_lat = (mode == 0);
            sb_q.push_back(e);
        end
        if (ok) send_ops(mode);
        op_a_q.delete();
        op_b_q.delete();
    endtask

    task automatic add_pairs(input int n, input logic [15:0] a, input logic [15:0] b);
        for (int k = 0; k < n; k++) begin
            op_a_q.push_back(a);
            op_b_q.push_back(b);
        end
    endtask

    function automatic logic [15:0] rand_op();
        if ($urandom_range(0, 40) == 0) return 16'hFFFF;
        return {1'($urandom_range(0, 1)), 6'($urandom_range(26, 36)), 9'($urandom_range(0, 511))};
    endfunction

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (sb_q.size() == 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            report_timeout("result_timeout");
            sb_q.delete();
        end
    endtask

    task automatic wait_res_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        if (!ok) report_timeout("res_valid_timeout");
    endtask

    task automatic watchdog();
        #500000;
        fails++;
        $display("[TB] FAIL watchdog: got no finish, required completion within time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    endtask

    task automatic check_output_idle(input string tag);
        check_output({tag, "_busy"}, int'(busy), 0);
        check_output({tag, "_mac_issue"}, int'(mac_issue), 0);
        check_output({tag, "_res_valid"}, int'(res_valid), 0);
        check_output({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        abort     = 1'b0;
        op_valid  = 1'b0;
        op_a      = 16'h0;
        op_b      = 16'h0;
        res_ready = 1'b0;
        fork
            monitor_loop();
            watchdog();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b1;

        // Three back-to-back 1.0*2.0 products accumulate to 6.0.
        add_pairs(3, 16'h3E00, 16'h4000);
        apply_stimulus(3, 0, 1'b1, 16'h4300);
        wait_drain();

        // Empty vector: cleared accumulator comes straight back.
        apply_stimulus(0, 0, 1'b1, 16'h0000);
        wait_drain();

        // Operand valid toggling creates bubbles that must not count as issues.
        add_pairs(4, 16'h3E00, 16'h4000);
        apply_stimulus(4, 1, 1'b1, 16'h4400);
        wait_drain();

        // Held result with a waiting command behind it.
        res_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            op_a_q.push_back(rand_op());
            op_b_q.push_back(16'h3E00);
        end
        apply_stimulus(2, 0, 1'b1, -1);
        wait_res_valid();
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(1);
        repeat (10) begin
            @(negedge clk);
            check_output("held_cmd_ready", int'(cmd_ready), 0);
            check_output("held_res_valid", int'(res_valid), 1);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        add_pairs(1, 16'h3E00, 16'h4000);
        apply_stimulus(1, 0, 1'b1, 16'h4000);
        wait_drain();

        // Abort in LOAD after two pairs; the third pair must not be taken.
        begin
            int t0;
            bit ok;
            send_cmd(4, t0, ok);
            add_pairs(2, 16'h3E00, 16'h4000);
            send_ops(0);
            op_a_q.delete();
            op_b_q.delete();
            op_valid = 1'b1;
            op_a     = 16'h4000;
            op_b     = 16'h4000;
            abort    = 1'b1;
            @(negedge clk);
            check_output("abort_op_ready", int'(op_ready), 0);
            @(posedge clk);
            #1;
            abort    = 1'b0;
            op_valid = 1'b0;
            @(negedge clk);
            check_output_idle("after_abort_load");
            repeat (8) @(posedge clk);
            #1;
        end
        add_pairs(1, 16'h3E00, 16'h3E00);
        apply_stimulus(1, 0, 1'b1, 16'h3E00);
        wait_drain();

        // Abort while the result is waiting drops it.
        res_ready = 1'b0;
        add_pairs(1, 16'h4000, 16'h4000);
        apply_stimulus(1, 0, 1'b0, -1);
        wait_res_valid();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check_output_idle("after_abort_done");
        @(posedge clk);
        #1;
        res_ready = 1'b1;

        // Special operand saturates the result and flags overflow.
        add_pairs(1, 16'hFFFF, 16'h3E00);
        apply_stimulus(1, 0, 1'b1, 16'hFFFF);
        wait_drain();

        // Reset in the middle of LOAD.
        begin
            int t0;
            bit ok;
            send_cmd(5, t0, ok);
            add_pairs(2, 16'h3E00, 16'h4000);
            send_ops(0);
            op_a_q.delete();
            op_b_q.delete();
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midload_reset");
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
        end

        // Maximum length exercises the counter compare at its top value.
        add_pairs(255, 16'h3E00, 16'h3E00);
        apply_stimulus(255, 0, 1'b1, -1);
        wait_drain();

        // Randomised lengths, operands, operand gaps and result back-pressure.
        for (int r = 0; r < 25; r++) begin
            int len;
            len = int'($urandom_range(0, 8));
            for (int k = 0; k < len; k++) begin
                op_a_q.push_back(rand_op());
                op_b_q.push_back(rand_op());
            end
            res_ready = 1'($urandom_range(0, 1));
            apply_stimulus(len, 2, 1'b1, -1);
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            res_ready = 1'b1;
            wait_drain();
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
